mem_arbiter: RTL

Shares the single-ported unified memory between the fetch stage (instruction port) and the memory stage (data port) of the five-stage WISC pipeline. Grants one requester at a time, issues a registered single-cycle request to the variable-latency memory, and returns read data with a valid pulse. It drives per-port stall outputs that the hazard logic uses to freeze the pipeline. Data requests win by default because they belong to the older instruction; an optional starvation guard bounds instruction-side wait.

---
 rtl/wisc_mem_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/arb_starve_ctr.sv | 41 ++++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/wisc_mem_pkg.sv
// Shared types and constants for the WISC unified-memory arbiter.
package wisc_mem_pkg;

  // Arbiter control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    I_WAIT = 2'd2,
    D_WAIT = 2'd3
  } arb_state_t;

  // Owner register encoding: which port holds the current grant
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Default bus widths for the WISC pipeline
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch-port, data-port and memory-side signals of the arbiter.
// slave: the arbiter's view. master: the pipeline/memory environment's view.
interface mem_arbiter_if import wisc_mem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  // Instruction (fetch) port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  // Data (memory stage) port
  logic              dm_req;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;

  // Unified memory side
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  dm_req, dm_wr, dm_addr, dm_wdata,
    input  mem_rdata, mem_done,
    output if_rdata, if_valid, if_stall,
    output dm_rdata, dm_valid, dm_stall,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    output dm_req, dm_wr, dm_addr, dm_wdata,
    output mem_rdata, mem_done,
    input  if_rdata, if_valid, if_stall,
    input  dm_rdata, dm_valid, dm_stall,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Fetch starvation counter for mem_arbiter (only built with ARB_STARVE_GUARD_EN).
// Counts data grants made while a fetch is waiting and flags when the
// allowance of STARVE_MAX consecutive data grants is used up.
module arb_starve_ctr import wisc_mem_pkg::*; #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,          // synchronous, active-low
  input  logic data_grant,   // data grant while if_req pending
  input  logic fetch_grant,  // any fetch grant
  input  logic clr,          // if_req low in IDLE
  output logic starve
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear on fetch service or idle fetch port, saturate at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (fetch_grant || clr) begin
      cnt_d = '0;
    end else if (data_grant && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported unified memory between the fetch
// port and the data port. Data requests win by default (older instruction).
// Optional build macro ARB_STARVE_GUARD_EN bounds how many consecutive data
// grants may pass a waiting fetch.
module mem_arbiter import wisc_mem_pkg::*; #(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,   // synchronous, active-low
  mem_arbiter_if.slave  bus
);

  if (STARVE_MAX < 1) begin : g_cfg_check
    $error("mem_arbiter: STARVE_MAX must be at least 1");
  end

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              killed_q, killed_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic data_grant;
  logic fetch_grant;
  logic fetch_ok;
  logic starve_hit;
  logic in_wait;
  logic i_done;
  logic d_done;

  // A flush in the grant cycle blocks the fetch for that cycle only
  assign fetch_ok = bus.if_req & ~bus.if_flush;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk         (clk),
    .rst         (rst),
    .data_grant  (data_grant & bus.if_req),
    .fetch_grant (fetch_grant),
    .clr         ((state_q == IDLE) & ~bus.if_req),
    .starve      (starve_hit)
  );
`else
  assign starve_hit = 1'b0;
`endif

  // Grant decision, next state, registered memory request and kill tracking
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    killed_d    = killed_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    data_grant  = 1'b0;
    fetch_grant = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.dm_req && !(starve_hit && fetch_ok)) begin
          data_grant = 1'b1;
        end else if (fetch_ok) begin
          fetch_grant = 1'b1;
        end

        if (data_grant) begin
          owner_d     = OWN_D;
          mem_en_d    = 1'b1;
          mem_wr_d    = bus.dm_wr;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          killed_d    = 1'b0;
          state_d     = ISSUE;
        end else if (fetch_grant) begin
          owner_d     = OWN_I;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          killed_d    = 1'b0;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        // mem_en is high during this state; mem_done here is ignored
        if ((owner_q == OWN_I) && bus.if_flush) begin
          killed_d = 1'b1;
        end
        state_d = (owner_q == OWN_I) ? I_WAIT : D_WAIT;
      end

      I_WAIT: begin
        if (bus.if_flush) begin
          killed_d = 1'b1;
        end
        if (bus.mem_done) begin
          killed_d = 1'b0;
          state_d  = IDLE;
        end
      end

      D_WAIT: begin
        if (bus.mem_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      killed_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      killed_q    <= killed_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Completion is combinational from mem_done so the pipeline unfreezes in
  // the same cycle; a killed (or same-cycle flushed) fetch never reports.
  assign in_wait = (state_q == I_WAIT) || (state_q == D_WAIT);
  assign i_done  = in_wait & (owner_q == OWN_I) & bus.mem_done;
  assign d_done  = in_wait & (owner_q == OWN_D) & bus.mem_done;

  assign bus.if_valid  = i_done & ~killed_q & ~bus.if_flush;
  assign bus.dm_valid  = d_done;
  assign bus.if_rdata  = bus.if_valid ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = bus.dm_valid ? bus.mem_rdata : '0;
  assign bus.if_stall  = bus.if_req & ~bus.if_valid;
  assign bus.dm_stall  = bus.dm_req & ~bus.dm_valid;

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
